mem_bus_arbiter: RTL and testbench

- Shares one synchronous single-port RAM/ROM between the cpu_core and a DMA/video requester.
- Sequences every memory access as a 2-cycle address/data slot.
- Stalls cpu_core through a clock-enable pulse, so cpu_core only advances when its read data is valid.
- Sits between cpu_core (addr/din) and the memory array in the top level.

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_bus_arbiter_arb_pick.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_arbiter_pkg
// Desc   : State and owner encodings shared by the memory bus arbiter blocks.
// Rev    : 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_ADDR = 3'd1,
    ST_CPU_DATA = 3'd2,
    ST_DMA_ADDR = 3'd3,
    ST_DMA_DATA = 3'd4
  } arb_state_t;

  localparam logic c_own_cpu = 1'b0;
  localparam logic c_own_dma = 1'b1;

  // Wide enough for MAX_LOCK up to 15.
  localparam int c_lock_w = 4;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : arb_pick
// Desc   : Combinational winner selector: lock-extended round-robin, CPU vs DMA.
// Rev    : 1.0
// ============================================================================
module arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic                cpu_req,
  input  logic                dma_req,
  input  logic                dma_lock,
  input  logic                last_owner,
  input  logic [c_lock_w-1:0] lock_cnt,
  output logic                winner,
  output logic                valid
);

  localparam logic [c_lock_w-1:0] c_max_lock = c_lock_w'(MAX_LOCK);

  always_comb begin
    valid  = cpu_req | dma_req;
    winner = c_own_cpu;
    if (cpu_req && dma_req) begin
      // A locked DMA burst may extend its ownership until the lock budget runs out.
      if (dma_lock && (last_owner == c_own_dma) && (lock_cnt < c_max_lock)) begin
        winner = c_own_dma;
      end else begin
        winner = (last_owner == c_own_cpu) ? c_own_dma : c_own_cpu;
      end
    end else if (dma_req) begin
      winner = c_own_dma;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_arbiter
// Desc   : Shares one single-port memory between cpu_core and a DMA requester
//          using 2-cycle address/data slots; stalls the CPU via cpu_ce.
// Rev    : 1.0
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ce,
  output logic [DATA_W-1:0] cpu_din,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [c_lock_w-1:0] c_max_lock = c_lock_w'(MAX_LOCK);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                r_last_owner;
  logic [c_lock_w-1:0] r_lock_cnt;
  logic                r_slot_we;
  logic [DATA_W-1:0]   r_cpu_hold;
  logic [DATA_W-1:0]   r_dma_hold;
  logic                w_decide;
  logic                w_pick_owner;
  logic                w_pick_valid;
  logic                w_grant_cpu;
  logic                w_grant_dma;

  assign w_decide = (r_state == ST_IDLE) || (r_state == ST_CPU_DATA) ||
                    (r_state == ST_DMA_DATA);

  arb_pick #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .dma_lock   (dma_lock),
    .last_owner (r_last_owner),
    .lock_cnt   (r_lock_cnt),
    .winner     (w_pick_owner),
    .valid      (w_pick_valid)
  );

  assign w_grant_cpu = w_decide && w_pick_valid && (w_pick_owner == c_own_cpu);
  assign w_grant_dma = w_decide && w_pick_valid && (w_pick_owner == c_own_dma);

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_CPU_ADDR: w_state_nxt = ST_CPU_DATA;
      ST_DMA_ADDR: w_state_nxt = ST_DMA_DATA;
      // IDLE, both DATA states, and any illegal code fall back to arbitration.
      default: begin
        if (w_grant_cpu) begin
          w_state_nxt = ST_CPU_ADDR;
        end else if (w_grant_dma) begin
          w_state_nxt = ST_DMA_ADDR;
        end
      end
    endcase
  end

  // Read data is forwarded straight from memory in the data cycle, then held.
  assign cpu_ce     = (r_state == ST_CPU_DATA);
  assign cpu_din    = (cpu_ce && !r_slot_we) ? mem_rdata : r_cpu_hold;
  assign dma_gnt    = (r_state == ST_DMA_ADDR);
  assign dma_rvalid = (r_state == ST_DMA_DATA) && !r_slot_we;
  assign dma_rdata  = dma_rvalid ? mem_rdata : r_dma_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= c_own_dma;
      r_lock_cnt   <= '0;
      r_slot_we    <= 1'b0;
      r_cpu_hold   <= '0;
      r_dma_hold   <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      mem_en    <= w_grant_cpu | w_grant_dma;
      mem_we    <= (w_grant_cpu & cpu_we) | (w_grant_dma & dma_we);
      mem_wdata <= w_grant_cpu ? cpu_wdata : (w_grant_dma ? dma_wdata : '0);

      if (w_grant_cpu) begin
        mem_addr     <= cpu_addr;
        r_slot_we    <= cpu_we;
        r_last_owner <= c_own_cpu;
      end else if (w_grant_dma) begin
        mem_addr     <= dma_addr;
        r_slot_we    <= dma_we;
        r_last_owner <= c_own_dma;
      end

      if (w_grant_cpu || !dma_lock) begin
        r_lock_cnt <= '0;
      end else if (w_grant_dma && (r_lock_cnt < c_max_lock)) begin
        r_lock_cnt <= r_lock_cnt + c_lock_w'(1);
      end

      if (cpu_ce && !r_slot_we) begin
        r_cpu_hold <= mem_rdata;
      end
      if (dma_rvalid) begin
        r_dma_hold <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_bus_arbiter
// Desc   : Directed bench for mem_bus_arbiter with a slot-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int MAX_LOCK = 4;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ce;
  logic [DATA_W-1:0] cpu_din;
  logic              dma_req;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_we;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_bus_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_ce     (cpu_ce),
    .cpu_din    (cpu_din),
    .dma_req    (dma_req),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_we     (dma_we),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_val(int a);
    logic [31:0] v;
    v = a;
    return (a == 2) ? 8'h69 : (v[7:0] ^ 8'h3C);
  endfunction

  // Environment memory: 1-cycle read latency.
  logic [7:0] ram [0:65535];
  bit         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) ram[i] <= rom_val(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- reference model (slot level) ----------------
  logic [7:0]  ref_mem [0:65535];
  bit          ref_ready = 1'b0;
  int          m_phase   = 0;   // 0 none, 1 address cycle, 2 data cycle
  int          m_owner   = 0;   // 0 CPU, 1 DMA
  int          m_last    = 1;
  int          m_lock    = 0;
  int          m_win;
  logic [15:0] m_addr    = '0;
  logic        m_we      = 1'b0;
  logic [7:0]  m_wdata   = '0;
  logic [7:0]  m_cpu_hold = '0;
  logic [7:0]  m_dma_hold = '0;

  function automatic int pick(bit c, bit d, bit lk, int last, int cnt);
    if (c && !d) return 0;
    if (d && !c) return 1;
    if (lk && last == 1 && cnt < MAX_LOCK) return 1;
    return 1 - last;
  endfunction

  always_comb m_win = pick(cpu_req, dma_req, dma_lock, m_last, m_lock);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase    <= 0;
      m_last     <= 1;
      m_lock     <= 0;
      m_cpu_hold <= '0;
      m_dma_hold <= '0;
    end else begin
      if (!ref_ready) begin
        for (int i = 0; i < 65536; i++) ref_mem[i] <= rom_val(i);
        ref_ready <= 1'b1;
      end
      if (m_phase == 2 && !m_we) begin
        if (m_owner == 0) m_cpu_hold <= ref_mem[m_addr];
        else              m_dma_hold <= ref_mem[m_addr];
      end
      if (m_phase == 1 && m_we) ref_mem[m_addr] <= m_wdata;

      if (m_phase == 1) begin
        m_phase <= 2;
        if (!dma_lock) m_lock <= 0;
      end else if (cpu_req || dma_req) begin
        m_phase <= 1;
        m_owner <= m_win;
        m_last  <= m_win;
        m_addr  <= (m_win == 0) ? cpu_addr  : dma_addr;
        m_we    <= (m_win == 0) ? cpu_we    : dma_we;
        m_wdata <= (m_win == 0) ? cpu_wdata : dma_wdata;
        if (m_win == 0 || !dma_lock) m_lock <= 0;
        else if (m_lock < MAX_LOCK)  m_lock <= m_lock + 1;
      end else begin
        m_phase <= 0;
        if (!dma_lock) m_lock <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("mem_en", mem_en, m_phase == 1);
      chk("mem_we", mem_we, (m_phase == 1) && m_we);
      chk("mem_wdata", mem_wdata, (m_phase == 1) ? m_wdata : 8'h00);
      if (m_phase == 1) chk("mem_addr", mem_addr, m_addr);
      chk("cpu_ce", cpu_ce, (m_phase == 2) && (m_owner == 0));
      chk("cpu_din", cpu_din,
          (m_phase == 2 && m_owner == 0 && !m_we) ? ref_mem[m_addr] : m_cpu_hold);
      chk("dma_gnt", dma_gnt, (m_phase == 1) && (m_owner == 1));
      chk("dma_rvalid", dma_rvalid, (m_phase == 2) && (m_owner == 1) && !m_we);
      chk("dma_rdata", dma_rdata,
          (m_phase == 2 && m_owner == 1 && !m_we) ? ref_mem[m_addr] : m_dma_hold);
    end
  end

  // ---------------- event logs for the directed literal checks ----------------
  int ce_t[$];
  int din_log[$];
  int gnt_t[$];
  int grant_log[$];
  int en_t[$];
  int we_log[$];
  int rv_log[$];

  always @(negedge clk) begin
    if (reset) begin
      if (cpu_ce) begin
        ce_t.push_back(cyc);
        din_log.push_back(int'(cpu_din));
      end
      if (dma_gnt) gnt_t.push_back(cyc);
      if (mem_en) begin
        grant_log.push_back(dma_gnt ? 1 : 0);
        en_t.push_back(cyc);
      end
      if (mem_we) we_log.push_back(dma_gnt ? 1 : 0);
      if (dma_rvalid) rv_log.push_back(cyc);
    end
  end

  task automatic clear_logs();
    ce_t.delete(); din_log.delete(); gnt_t.delete(); grant_log.delete();
    en_t.delete(); we_log.delete(); rv_log.delete();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int gap(input int q[$]);
    return (q.size() >= 2) ? (q[1] - q[0]) : -1;
  endfunction

  task automatic idle_inputs();
    cpu_req = 0; cpu_addr = '0; cpu_we = 0; cpu_wdata = '0;
    dma_req = 0; dma_lock = 0; dma_addr = '0; dma_we = 0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    bit ok;
    int rel;
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_cpu_din", cpu_din, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // 1. CPU-only reads of ROM[2]
    cpu_addr = 16'h0002; cpu_req = 1;
    clear_logs();
    repeat (8) @(posedge clk); #2;
    chk("t1_din", qget(din_log, 0), 32'h69);
    chk("t1_ce_gap", gap(ce_t), 2);
    chk("t1_we_count", we_log.size(), 0);
    idle_inputs();

    // 2. Contention without lock
    do_reset();
    cpu_addr = 16'h0002; dma_addr = 16'h0010; cpu_req = 1; dma_req = 1;
    clear_logs();
    repeat (12) @(posedge clk); #2;
    chk("t2_g0", qget(grant_log, 0), 0);
    chk("t2_g1", qget(grant_log, 1), 1);
    chk("t2_g2", qget(grant_log, 2), 0);
    chk("t2_g3", qget(grant_log, 3), 1);
    chk("t2_ce_gap", gap(ce_t), 4);
    chk("t2_gnt_after_ce", qget(gnt_t, 0) - qget(ce_t, 0), 1);
    idle_inputs();

    // 3. Locked burst with the CPU waiting
    do_reset();
    cpu_addr = 16'h0002; dma_addr = 16'h0010;
    cpu_req = 1; dma_req = 1; dma_lock = 1;
    clear_logs();
    repeat (24) @(posedge clk); #2;
    chk("t3_g0", qget(grant_log, 0), 1);
    chk("t3_g1", qget(grant_log, 1), 1);
    chk("t3_g2", qget(grant_log, 2), 1);
    chk("t3_g3", qget(grant_log, 3), 1);
    chk("t3_g4", qget(grant_log, 4), 0);
    chk("t3_g5", qget(grant_log, 5), 1);
    chk("t3_ce_gap", gap(ce_t), 2 * MAX_LOCK + 2);
    idle_inputs();

    // 4. DMA write, then CPU reads it back
    do_reset();
    dma_addr = 16'h0100; dma_we = 1; dma_wdata = 8'hA5; dma_req = 1;
    clear_logs();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dma_gnt) begin ok = 1; break; end
    end
    chk("t4_gnt_seen", ok, 1);
    @(posedge clk); #2;
    dma_req = 0; dma_we = 0;
    cpu_addr = 16'h0100; cpu_req = 1;
    repeat (6) @(posedge clk); #2;
    chk("t4_din", qget(din_log, 0), 32'hA5);
    chk("t4_rvalid_count", rv_log.size(), 0);
    chk("t4_we_count", we_log.size(), 1);
    chk("t4_we_in_dma_addr", qget(we_log, 0), 1);
    idle_inputs();

    // 5. Asynchronous reset during a CPU write address cycle
    do_reset();
    cpu_addr = 16'h0200; cpu_we = 1; cpu_wdata = 8'h5A; cpu_req = 1;
    dma_addr = 16'h0010; dma_req = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en && !dma_gnt) begin ok = 1; break; end
    end
    chk("t5_cpu_addr_seen", ok, 1);
    chk("t5_pre_mem_we", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_mem_en", mem_en, 0);
    chk("t5_async_mem_we", mem_we, 0);
    chk("t5_async_cpu_ce", cpu_ce, 0);
    chk("t5_async_dma_gnt", dma_gnt, 0);
    repeat (2) @(posedge clk); #2;
    clear_logs();
    rel = cyc;
    reset = 1'b1;
    repeat (4) @(posedge clk); #2;
    chk("t5_first_grant_cpu", qget(grant_log, 0), 0);
    chk("t5_first_grant_cycle", qget(en_t, 0), rel + 1);
    idle_inputs();

    // 6. DMA request withdrawn before any decision point
    do_reset();
    cpu_addr = 16'h0002; cpu_req = 1;
    clear_logs();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en) begin ok = 1; break; end
    end
    chk("t6_cpu_addr_seen", ok, 1);
    #1 dma_req = 1; dma_addr = 16'h0010;
    @(posedge clk); #2 dma_req = 0;
    repeat (6) @(posedge clk); #2;
    chk("t6_no_dma_gnt", gnt_t.size(), 0);
    chk("t6_ce_gap", gap(ce_t), 2);
    chk("t6_g1_cpu", qget(grant_log, 1), 0);
    idle_inputs();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
